// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM duty/period/high-time capture with stuck-input timeout
//
// Measures an asynchronous PWM input in prescaled ticks (one tick every
// CLK_DIV+1 clocks) and reports the high time, the period between rising edges
// and an 8-bit duty code. If no edge is seen for TIMEOUT ticks, the input is
// reported as stuck at its current level.
//
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   en           capture enable (level); low forces IDLE and clears counters
//   pwm_in       asynchronous PWM input
//   duty         min(high_time, 255), or 8'h00/8'hFF when stuck
//   period       ticks between the last two rising edges
//   high_time    ticks the input was high during that period
//   meas_valid   one-cycle strobe whenever duty/period/high_time update
//   stuck        no edge for TIMEOUT ticks
//   stuck_level  synchronized input level when stuck was declared

module pwm_capture #(
  parameter int CLK_DIV = 12,
  parameter int CNT_W   = 10,
  parameter int TIMEOUT = 512
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             pwm_in,
  output logic [7:0]       duty,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             stuck,
  output logic             stuck_level
);

  localparam int                 DIV_W   = $clog2(CLK_DIV + 2);
  localparam logic [DIV_W-1:0]   DIV_MAX = DIV_W'(CLK_DIV);
  localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   TO_VAL  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]   DUTY_MAX = CNT_W'(255);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic             s1, s2, s_prev;
  logic             rise, fall, any_edge;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [CNT_W-1:0] period_cnt, high_cnt, age_cnt;
  logic             timeout_hit;

  // Two-flop synchronizer plus a delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s_prev <= 1'b0;
    end else begin
      s1     <= pwm_in;
      s2     <= s1;
      s_prev <= s2;
    end
  end

  assign rise     = s2 & ~s_prev;
  assign fall     = ~s2 & s_prev;
  assign any_edge = rise | fall;

  // Prescaler: free-running only while enabled so ticks restart cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (!en || div_cnt == DIV_MAX) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick = en && (div_cnt == DIV_MAX);

  // Fires once: stuck=1 blocks re-arming until an edge clears it, and an
  // edge in the same cycle always wins over the timeout.
  assign timeout_hit = en && (state != IDLE) && (age_cnt == TO_VAL) &&
                       !stuck && !any_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = ARM;
        ARM:     if (rise) state_nxt = MEASURE;
        MEASURE: if (timeout_hit) state_nxt = ARM;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt  <= '0;
      high_cnt    <= '0;
      age_cnt     <= '0;
      duty        <= '0;
      period      <= '0;
      high_time   <= '0;
      meas_valid  <= 1'b0;
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (!en || state == IDLE) begin
        // Reported values hold; only the running counters are dropped.
        period_cnt <= '0;
        high_cnt   <= '0;
        age_cnt    <= '0;
        stuck      <= 1'b0;
      end else begin
        if (any_edge) begin
          age_cnt <= '0;
          stuck   <= 1'b0;
        end else if (tick && age_cnt != TO_VAL) begin
          age_cnt <= age_cnt + 1'b1;
        end

        if (timeout_hit) begin
          stuck       <= 1'b1;
          stuck_level <= s2;
          duty        <= s2 ? 8'hFF : 8'h00;
          period      <= '0;
          high_time   <= '0;
          meas_valid  <= 1'b1;
        end

        case (state)
          ARM: begin
            if (rise) begin
              period_cnt <= '0;
              high_cnt   <= '0;
            end
          end
          MEASURE: begin
            if (rise) begin
              period     <= period_cnt;
              high_time  <= high_cnt;
              duty       <= (high_cnt > DUTY_MAX) ? 8'hFF : high_cnt[7:0];
              meas_valid <= 1'b1;
              period_cnt <= '0;
              high_cnt   <= '0;
            end else if (tick) begin
              if (period_cnt != CNT_MAX) period_cnt <= period_cnt + 1'b1;
              if (s2 && high_cnt != CNT_MAX) high_cnt <= high_cnt + 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed self-checking bench for pwm_capture
//
// A local PWM generator with the same tick divider drives pwm_in; its duty
// change takes effect at the start of the next 256-tick period.

module tb_pwm_capture;

  localparam int DIV     = 3;
  localparam int CNT_W   = 10;
  localparam int TIMEOUT = 512;
  localparam int PER_CLK = 256 * (DIV + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             pwm_in;
  logic [7:0]       duty;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             stuck;
  logic             stuck_level;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int gen_duty  = 128;
  int gen_cur   = 0;
  int gen_cnt   = 0;
  int gen_div   = 0;
  int gen_rises = 0;
  int edge_cyc  = 0;

  pwm_capture #(.CLK_DIV(DIV), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .pwm_in      (pwm_in),
    .duty        (duty),
    .period      (period),
    .high_time   (high_time),
    .meas_valid  (meas_valid),
    .stuck       (stuck),
    .stuck_level (stuck_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // PWM generator: duty 255 means constant high, otherwise high for gen_cnt < duty.
  initial begin
    logic nv;
    pwm_in = 1'b0;
    forever begin
      @(negedge clk);
      if (gen_div == DIV) begin
        gen_div = 0;
        if (gen_cnt == 255) begin
          gen_cnt = 0;
          gen_cur = gen_duty;
        end else begin
          gen_cnt++;
        end
      end else begin
        gen_div++;
      end
      nv = (gen_cur == 255) ? 1'b1 : (gen_cnt < gen_cur);
      if (nv != pwm_in) begin
        edge_cyc = cyc;
        if (nv) gen_rises++;
      end
      pwm_in = nv;
    end
  end

  task automatic wait_valid(input int budget, output bit got);
    int n;
    n = 0;
    got = 1'b0;
    while (!got && n < budget) begin
      @(posedge clk); #1;
      n++;
      if (meas_valid === 1'b1) got = 1'b1;
    end
  endtask

  task automatic wait_stuck(input bit val, input int budget, output bit got, output int strobes);
    int n;
    n = 0;
    got = 1'b0;
    strobes = 0;
    while (!got && n < budget) begin
      @(posedge clk); #1;
      n++;
      if (stuck === val) got = 1'b1;
      else if (meas_valid === 1'b1) strobes++;
    end
  endtask

  task automatic wait_gen(input int v, input int budget, output bit got);
    int n;
    n = 0;
    got = 1'b0;
    while (!got && n < budget) begin
      @(posedge clk); #1;
      n++;
      if (gen_cnt == v) got = 1'b1;
    end
  endtask

  task automatic test_reset;
    int n;
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({duty, period, high_time, meas_valid, stuck, stuck_level} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got duty=%0d period=%0d high=%0d mv=%0b stuck=%0b lvl=%0b exp all 0",
               duty, period, high_time, meas_valid, stuck, stuck_level);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (meas_valid === 1'b1) n++;
    end
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL reset_idle_strobes got=%0d exp=0", n);
    end
  endtask

  task automatic test_duty128;
    bit got;
    int r0;
    wait_gen(200, 2 * PER_CLK, got);
    en = 1'b1;
    r0 = gen_rises;
    wait_valid(2 * PER_CLK + 400, got);
    checks++;
    if (got !== 1'b1) begin failures++; $display("FAIL d128_first_strobe got=%0b exp=1", got); end
    checks++;
    if (gen_rises - r0 != 2) begin failures++; $display("FAIL d128_rises_before_strobe got=%0d exp=2", gen_rises - r0); end
    checks++;
    if (!(period >= 255 && period <= 257)) begin failures++; $display("FAIL d128_period got=%0d exp=255..257", period); end
    checks++;
    if (!(high_time >= 127 && high_time <= 129)) begin failures++; $display("FAIL d128_high got=%0d exp=127..129", high_time); end
    checks++;
    if (!(duty >= 127 && duty <= 129)) begin failures++; $display("FAIL d128_duty got=%0d exp=127..129", duty); end
    checks++;
    if (stuck !== 1'b0) begin failures++; $display("FAIL d128_stuck got=%0b exp=0", stuck); end
    @(posedge clk); #1;
    checks++;
    if (meas_valid !== 1'b0) begin failures++; $display("FAIL d128_strobe_width got=%0b exp=0", meas_valid); end
    wait_valid(PER_CLK + 100, got);
    checks++;
    if (got !== 1'b1 || !(period >= 255 && period <= 257) || !(duty >= 127 && duty <= 129)) begin
      failures++;
      $display("FAIL d128_second got=%0b period=%0d duty=%0d exp strobe,255..257,127..129", got, period, duty);
    end
  endtask

  task automatic test_duty_extremes;
    int dvals[2] = '{1, 254};
    bit got;
    for (int i = 0; i < 2; i++) begin
      gen_duty = dvals[i];
      wait_valid(PER_CLK + 100, got);
      wait_valid(PER_CLK + 100, got);
      checks++;
      if (got !== 1'b1) begin failures++; $display("FAIL ext%0d_strobe got=%0b exp=1", dvals[i], got); end
      checks++;
      if (!(period >= 255 && period <= 257)) begin failures++; $display("FAIL ext%0d_period got=%0d exp=255..257", dvals[i], period); end
      checks++;
      if (!(int'(duty) >= dvals[i] - 1 && int'(duty) <= dvals[i] + 1)) begin
        failures++; $display("FAIL ext%0d_duty got=%0d exp=%0d..%0d", dvals[i], duty, dvals[i] - 1, dvals[i] + 1);
      end
      checks++;
      if (!(int'(high_time) >= dvals[i] - 1 && int'(high_time) <= dvals[i] + 1)) begin
        failures++; $display("FAIL ext%0d_high got=%0d exp=%0d..%0d", dvals[i], high_time, dvals[i] - 1, dvals[i] + 1);
      end
    end
  endtask

  task automatic test_stuck_low;
    bit got;
    int n;
    int dt;
    gen_duty = 0;
    wait_stuck(1'b1, 5 * PER_CLK, got, n);
    dt = cyc - edge_cyc;
    checks++;
    if (got !== 1'b1) begin failures++; $display("FAIL stlow_declared got=%0b exp=1", got); end
    checks++;
    if (meas_valid !== 1'b1) begin failures++; $display("FAIL stlow_strobe got=%0b exp=1", meas_valid); end
    checks++;
    if (stuck_level !== 1'b0 || duty !== 8'h00 || period !== '0 || high_time !== '0) begin
      failures++;
      $display("FAIL stlow_values got lvl=%0b duty=%0d period=%0d high=%0d exp 0,0,0,0", stuck_level, duty, period, high_time);
    end
    checks++;
    if (!(dt >= 2040 && dt <= 2064)) begin failures++; $display("FAIL stlow_delay got=%0d exp=2040..2064", dt); end
    @(posedge clk); #1;
    checks++;
    if (meas_valid !== 1'b0) begin failures++; $display("FAIL stlow_single_strobe got=%0b exp=0", meas_valid); end
    gen_duty = 64;
    wait_stuck(1'b0, 3 * PER_CLK, got, n);
    checks++;
    if (got !== 1'b1 || n != 0) begin failures++; $display("FAIL stlow_clear got=%0b strobes=%0d exp 1,0", got, n); end
    checks++;
    if (meas_valid !== 1'b0) begin failures++; $display("FAIL stlow_clear_strobe got=%0b exp=0", meas_valid); end
    wait_valid(PER_CLK + 200, got);
    checks++;
    if (got !== 1'b1 || !(duty >= 63 && duty <= 65) || !(period >= 255 && period <= 257) || stuck !== 1'b0) begin
      failures++;
      $display("FAIL stlow_recover got strobe=%0b duty=%0d period=%0d stuck=%0b exp 1,63..65,255..257,0", got, duty, period, stuck);
    end
  endtask

  task automatic test_stuck_high;
    bit got;
    int n;
    gen_duty = 255;
    wait_stuck(1'b1, 5 * PER_CLK, got, n);
    checks++;
    if (got !== 1'b1 || meas_valid !== 1'b1) begin failures++; $display("FAIL sthigh_declared got stuck=%0b mv=%0b exp 1,1", got, meas_valid); end
    checks++;
    if (stuck_level !== 1'b1 || duty !== 8'hFF || period !== '0 || high_time !== '0) begin
      failures++;
      $display("FAIL sthigh_values got lvl=%0b duty=%0h period=%0d high=%0d exp 1,ff,0,0", stuck_level, duty, period, high_time);
    end
    n = 0;
    repeat (2 * TIMEOUT * (DIV + 1)) begin
      @(posedge clk); #1;
      if (meas_valid === 1'b1) n++;
    end
    checks++;
    if (n != 0) begin failures++; $display("FAIL sthigh_repeat_strobes got=%0d exp=0", n); end
    checks++;
    if (stuck !== 1'b1) begin failures++; $display("FAIL sthigh_hold got=%0b exp=1", stuck); end
  endtask

  task automatic test_enable;
    bit got;
    int n;
    int stage;
    int k;
    int r0;
    gen_duty = 128;
    wait_stuck(1'b0, 3 * PER_CLK, got, n);
    checks++;
    if (got !== 1'b1 || n != 0) begin failures++; $display("FAIL en_unstick got=%0b strobes=%0d exp 1,0", got, n); end
    wait_valid(3 * PER_CLK, got);
    checks++;
    if (got !== 1'b1 || !(duty >= 127 && duty <= 129)) begin failures++; $display("FAIL en_pre got strobe=%0b duty=%0d exp 1,127..129", got, duty); end
    wait_gen(64, PER_CLK + 100, got);
    en = 1'b0;
    stage = 0;
    k = 0;
    n = 0;
    while (stage < 2 && k < 3 * PER_CLK) begin
      @(posedge clk); #1;
      k++;
      if (meas_valid === 1'b1) n++;
      if (stage == 0 && gen_cnt == 0) stage = 1;
      else if (stage == 1 && gen_cnt == 200) stage = 2;
    end
    checks++;
    if (stage != 2 || n != 0) begin failures++; $display("FAIL en_off_strobes got stage=%0d strobes=%0d exp 2,0", stage, n); end
    checks++;
    if (!(duty >= 127 && duty <= 129) || !(period >= 255 && period <= 257) || !(high_time >= 127 && high_time <= 129) || stuck !== 1'b0) begin
      failures++;
      $display("FAIL en_off_hold got duty=%0d period=%0d high=%0d stuck=%0b exp 127..129,255..257,127..129,0", duty, period, high_time, stuck);
    end
    en = 1'b1;
    r0 = gen_rises;
    wait_valid(2 * PER_CLK + 400, got);
    checks++;
    if (got !== 1'b1 || gen_rises - r0 != 2) begin failures++; $display("FAIL en_on_first got strobe=%0b rises=%0d exp 1,2", got, gen_rises - r0); end
    checks++;
    if (!(duty >= 127 && duty <= 129) || !(period >= 255 && period <= 257)) begin
      failures++; $display("FAIL en_on_values got duty=%0d period=%0d exp 127..129,255..257", duty, period);
    end
  endtask

  task automatic test_reset_mid;
    bit got;
    int r0;
    wait_valid(2 * PER_CLK, got);
    repeat (400) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({duty, period, high_time, meas_valid, stuck, stuck_level} !== '0) begin
      failures++;
      $display("FAIL rstmid_async got duty=%0d period=%0d high=%0d mv=%0b stuck=%0b lvl=%0b exp all 0",
               duty, period, high_time, meas_valid, stuck, stuck_level);
    end
    repeat (3) @(posedge clk);
    wait_gen(200, PER_CLK + 100, got);
    rst_n = 1'b1;
    r0 = gen_rises;
    wait_valid(2 * PER_CLK + 400, got);
    checks++;
    if (got !== 1'b1 || gen_rises - r0 != 2) begin failures++; $display("FAIL rstmid_first got strobe=%0b rises=%0d exp 1,2", got, gen_rises - r0); end
    checks++;
    if (!(duty >= 127 && duty <= 129) || !(period >= 255 && period <= 257)) begin
      failures++; $display("FAIL rstmid_values got duty=%0d period=%0d exp 127..129,255..257", duty, period);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    test_reset();
    test_duty128();
    test_duty_extremes();
    test_stuck_low();
    test_stuck_high();
    test_enable();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Measures an incoming PWM waveform and reports its duty cycle, period and high time in prescaled ticks.
- The tick rate matches the PWM generator's divider, so a 256-tick period reads back directly as the generator's 8-bit duty code.
- Used for loopback self-test of PWM outputs and for decoding external PWM inputs.
- Detects stuck signals (0 % / 100 % duty, no edges) with a timeout.

Parameters:
- CLK_DIV, 12: one tick every CLK_DIV+1 clk cycles.
- CNT_W, 10: width of the period and high-time counters.
- TIMEOUT, 512: ticks without any edge before the stuck flag is declared; must be < 2^CNT_W-1.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  capture enable, level-sensitive
- pwm_in  input  1  asynchronous PWM input
- duty  output  8  measured duty code, min(high_time,255)
- period  output  CNT_W  ticks between last two rising edges
- high_time  output  CNT_W  ticks the input was high in the last period
- meas_valid  output  1  one-cycle strobe when outputs update
- stuck  output  1  no edge for TIMEOUT ticks
- stuck_level  output  1  synchronized level when stuck was declared

Behaviour:
- Reset and clock: reset rst_n, asynchronous, active-low; clock clk. All flops, outputs and state clear to 0 on reset; state is IDLE.
- Synchronizer:
  - pwm_in passes through 2 flops (s1, s2), plus s_prev.
  - rise = s2 & ~s_prev; fall = ~s2 & s_prev.
  - Outputs update at the 3rd clk edge after pwm_in changes (setup met).
- Prescaler:
  - div_cnt counts 0..CLK_DIV while en=1; tick=1 when div_cnt==CLK_DIV, after which div_cnt wraps to 0.
  - div_cnt is held at 0 while en=0.
- States:
  - IDLE: en=0. Counters cleared, stuck cleared; duty/period/high_time hold their last values. On en=1, go to ARM.
  - ARM: wait for the first rise. On rise, clear period_cnt, high_cnt and age_cnt, then go to MEASURE. No meas_valid is issued for this first edge.
  - MEASURE, on tick (not on a rise cycle):
    - period_cnt += 1, saturating at 2^CNT_W-1.
    - high_cnt += 1 if s2=1, saturating.
  - MEASURE, on rise:
    - Register period<=period_cnt, high_time<=high_cnt, duty<=min(high_cnt,255), meas_valid<=1 for one cycle.
    - Clear the counters; a tick coincident with the rise is discarded.
  - en=0 in any state: go to IDLE on the next edge. This takes priority over edges and timeout.
- Timeout:
  - age_cnt counts ticks in ARM and MEASURE and clears on any rise or fall.
  - When age_cnt reaches TIMEOUT with stuck=0:
    - stuck<=1, stuck_level<=s2.
    - duty<=s2 ? 8'hFF : 8'h00; period<=0; high_time<=0.
    - meas_valid pulses once; state goes to ARM.
  - age_cnt then saturates at TIMEOUT with no further strobes.
  - stuck clears on the next rise or fall, with no strobe; a normal measurement follows after two rises.
- Boundaries:
  - A high pulse shorter than one tick reports high_time=0 but still produces a valid period.
  - A glitch narrower than 1 clk may be missed; this is acceptable.
  - A rise and a timeout in the same cycle: the rise wins.
  - Reset mid-measurement aborts immediately, returns to IDLE, and all outputs read 0.

Test Plan:
- Generator duty 128, same CLK_DIV, en=1: from the 2nd rise on, each rise gives meas_valid=1 for exactly 1 clk, period=256±1, high_time=128±1, duty=128±1; stuck=0.
- Generator duty 1, then 254: duty=1±1 with period 256±1; then duty=254±1 with period 256±1.
- Generator duty 0 (constant low): TIMEOUT ticks after the last edge, stuck=1, stuck_level=0, duty=8'h00, period=0, single meas_valid. Then switch to duty 64: stuck clears at the first edge, and duty=64±1 after two rises.
- Generator duty 8'hFF (constant high): stuck=1, stuck_level=1, duty=8'hFF, single meas_valid, no repeat strobes for 2*TIMEOUT ticks.
- en toggled low mid-period: state IDLE, no meas_valid, outputs hold. On en high, the first strobe comes only after two rises.
- rst_n pulsed low mid-MEASURE: all outputs 0 asynchronously. After release with en=1, the first valid measurement occurs at the 2nd rise.
